// File: rtl/id_fetch_queue.sv
// ---------------------------------------------------------------------------
// id_fetch_queue
//   Instruction queue between fetch and decode. Holds up to DEPTH fetched
//   instructions with their PC, branch-delay flag and fetch exception code.
//   The head entry is presented to decode together with PC+4/PC+8 and an
//   exception code that merges the fetch exception with a reserved-
//   instruction check. A flush discards every buffered entry.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   fetch presents an entry
//   in_ready   queue accepts an entry this cycle
//   in_instr   fetched instruction word
//   in_pc      PC of the fetched instruction
//   in_bd      instruction sits in a branch delay slot
//   in_exc     fetch exception code (0 = none)
//   flush      synchronous discard of all entries
//   out_ready  decode accepts the head entry
//   out_valid  head entry present
//   IR_D       head instruction (0 when empty)
//   PC_D       head PC, or PC of the last dequeued entry when empty
//   PC4_D      PC_D + 4
//   PC8_D      PC_D + 8
//   BD_D       head delay-slot flag (0 when empty)
//   excode_D   head exception code (0 when empty)
//   count      current occupancy
// ---------------------------------------------------------------------------
module id_fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter bit          RI_CHECK = 1'b1,
  parameter logic [4:0]  EXC_RI   = 5'd10,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  input  logic                       in_bd,
  input  logic [4:0]                 in_exc,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                IR_D,
  output logic [31:0]                PC_D,
  output logic [31:0]                PC4_D,
  output logic [31:0]                PC8_D,
  output logic                       BD_D,
  output logic [4:0]                 excode_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [31:0]     last_pc_q, last_pc_d;

  entry_t          head;
  logic            push;
  logic            pop;
  logic            recognised;

  // Decode-time legality check of a MIPS-I subset plus mfc0/mtc0/eret.
  function automatic logic is_recognised(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,   // shifts
          6'h08, 6'h09,                               // jr, jalr
          6'h10, 6'h11, 6'h12, 6'h13,                 // mfhi, mthi, mflo, mtlo
          6'h18, 6'h19, 6'h1A, 6'h1B,                 // mult/multu/div/divu
          6'h20, 6'h21, 6'h22, 6'h23,                 // add/addu/sub/subu
          6'h24, 6'h25, 6'h26, 6'h27,                 // and/or/xor/nor
          6'h2A, 6'h2B:                               // slt/sltu
            ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      6'h01:  ok = (w[20:16] == 5'd0) || (w[20:16] == 5'd1);
      6'h10:  ok = (w[25:21] == 5'd0) || (w[25:21] == 5'd4) ||
                   (w == 32'h4200_0018);
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,       // j jal beq bne blez bgtz
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,       // addi .. ori
      6'h0E, 6'h0F,                                   // xori lui
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,              // lb lh lw lbu lhu
      6'h28, 6'h29, 6'h2B:                            // sb sh sw
        ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  // A full queue can still accept when decode drains the head this cycle.
  assign in_ready  = (count_q < CW'(DEPTH)) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    mem_d     = mem_q;

    if (flush) begin
      // Flush wins over push and pop: the incoming entry is dropped and
      // last_pc keeps the PC of the last entry decode actually consumed.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: in_instr, pc: in_pc, bd: in_bd, exc: in_exc};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        last_pc_d = head.pc;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // NOTE: the entry storage is deliberately left unreset; every output it
  // feeds is gated by out_valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign recognised = is_recognised(head.instr);

  always_comb begin
    excode_D = 5'd0;
    if (out_valid) begin
      if (head.exc != 5'd0)             excode_D = head.exc;
      else if (RI_CHECK && !recognised) excode_D = EXC_RI;
    end
  end

  assign IR_D  = out_valid ? head.instr : 32'h0;
  assign PC_D  = out_valid ? head.pc    : last_pc_q;
  assign BD_D  = out_valid & head.bd;
  assign PC4_D = PC_D + 32'd4;
  assign PC8_D = PC_D + 32'd8;
  assign count = count_q;

endmodule

// File: tb/tb_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_id_fetch_queue
//   Directed bench for id_fetch_queue (DEPTH=2). A second instance with
//   RI_CHECK=0 shares all inputs so the reserved-instruction case can be
//   compared against both settings. Inputs change and outputs are sampled
//   1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_id_fetch_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_bd, flush, out_ready;
  logic [31:0]   in_instr, in_pc;
  logic [4:0]    in_exc;

  logic          in_ready, out_valid, BD_D;
  logic [31:0]   IR_D, PC_D, PC4_D, PC8_D;
  logic [4:0]    excode_D;
  logic [CW-1:0] count;

  logic          n_in_ready, n_out_valid, n_BD_D;
  logic [31:0]   n_IR_D, n_PC_D, n_PC4_D, n_PC8_D;
  logic [4:0]    n_excode_D;
  logic [CW-1:0] n_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_fetch_queue #(.DEPTH(DEPTH), .RI_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D), .PC8_D(PC8_D),
    .BD_D(BD_D), .excode_D(excode_D), .count(count)
  );

  id_fetch_queue #(.DEPTH(DEPTH), .RI_CHECK(1'b0)) dut_nori (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .flush(flush), .out_ready(out_ready), .out_valid(n_out_valid),
    .IR_D(n_IR_D), .PC_D(n_PC_D), .PC4_D(n_PC4_D), .PC8_D(n_PC8_D),
    .BD_D(n_BD_D), .excode_D(n_excode_D), .count(n_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    in_bd    = bd;
    in_exc   = exc;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (IR_D !== 32'h0) begin n_fail++; $display("FAIL reset_IR_D got %h want 0", IR_D); end
    n_checks++; if (PC_D !== 32'h3000) begin n_fail++; $display("FAIL reset_PC_D got %h want 3000", PC_D); end
    n_checks++; if (PC4_D !== 32'h3004) begin n_fail++; $display("FAIL reset_PC4_D got %h want 3004", PC4_D); end
    n_checks++; if (PC8_D !== 32'h3008) begin n_fail++; $display("FAIL reset_PC8_D got %h want 3008", PC8_D); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (excode_D !== 5'd0 || BD_D !== 1'b0) begin n_fail++; $display("FAIL reset_exc_bd got %0d/%0b want 0/0", excode_D, BD_D); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 32'h3C01_0001, 32'h3000, 1'b0, 5'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", out_valid); end
    n_checks++; if (IR_D !== 32'h3C01_0001) begin n_fail++; $display("FAIL single_IR_D got %h want 3c010001", IR_D); end
    n_checks++; if (PC4_D !== 32'h3004) begin n_fail++; $display("FAIL single_PC4_D got %h want 3004", PC4_D); end
    n_checks++; if (PC8_D !== 32'h3008) begin n_fail++; $display("FAIL single_PC8_D got %h want 3008", PC8_D); end
    n_checks++; if (excode_D !== 5'd0) begin n_fail++; $display("FAIL single_excode got %0d want 0", excode_D); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
    n_checks++; if (IR_D !== 32'h0) begin n_fail++; $display("FAIL single_drain_IR got %h want 0", IR_D); end
    n_checks++; if (PC_D !== 32'h3000) begin n_fail++; $display("FAIL single_drain_PC got %h want 3000", PC_D); end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    drive(1'b1, 32'h2401_0001, 32'h3000, 1'b0, 5'd0); step();
    drive(1'b1, 32'h2401_0002, 32'h3004, 1'b1, 5'd0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
    n_checks++; if (PC_D !== 32'h3000) begin n_fail++; $display("FAIL full_head got %h want 3000", PC_D); end
    out_ready = 1'b1;
    drive(1'b1, 32'h2401_0003, 32'h3008, 1'b0, 5'd0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready_pop got %0b want 1", in_ready); end
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL pushpop_count got %0d want 2", count); end
    n_checks++; if (PC_D !== 32'h3004 || BD_D !== 1'b1) begin n_fail++; $display("FAIL pushpop_head got %h/%0b want 3004/1", PC_D, BD_D); end
    step();
    n_checks++; if (PC_D !== 32'h3008 || IR_D !== 32'h2401_0003) begin n_fail++; $display("FAIL pushpop_second got %h/%h want 3008/24010003", PC_D, IR_D); end
    step();
    n_checks++; if (count !== 2'd0 || PC_D !== 32'h3008) begin n_fail++; $display("FAIL drain got %0d/%h want 0/3008", count, PC_D); end
  endtask

  task automatic test_ri();
    out_ready = 1'b0;
    drive(1'b1, 32'hFC00_0000, 32'h5000, 1'b0, 5'd0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd10) begin n_fail++; $display("FAIL ri_on got %0d want 10", excode_D); end
    n_checks++; if (n_excode_D !== 5'd0) begin n_fail++; $display("FAIL ri_off got %0d want 0", n_excode_D); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    drive(1'b1, 32'hFC00_0000, 32'h5004, 1'b0, 5'd4); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd4) begin n_fail++; $display("FAIL fetch_exc_on got %0d want 4", excode_D); end
    n_checks++; if (n_excode_D !== 5'd4) begin n_fail++; $display("FAIL fetch_exc_off got %0d want 4", n_excode_D); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // A few legal encodings across the opcode classes must not raise RI.
    drive(1'b1, 32'h0000_0000, 32'h5008, 1'b0, 5'd0); step();              // sll nop
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd0) begin n_fail++; $display("FAIL nop_exc got %0d want 0", excode_D); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    drive(1'b1, 32'h0000_0005, 32'h500C, 1'b0, 5'd0); step();              // SPECIAL funct 5
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd10) begin n_fail++; $display("FAIL special5_exc got %0d want 10", excode_D); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    drive(1'b1, 32'h4080_6000, 32'h5010, 1'b0, 5'd0); step();              // mtc0
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd0) begin n_fail++; $display("FAIL mtc0_exc got %0d want 0", excode_D); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    drive(1'b1, 32'h0402_0000, 32'h5014, 1'b0, 5'd0); step();              // REGIMM rt=2
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (excode_D !== 5'd10) begin n_fail++; $display("FAIL regimm2_exc got %0d want 10", excode_D); end
    out_ready = 1'b1; step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h2401_0011, 32'h4000, 1'b0, 5'd0); step();
    drive(1'b1, 32'h2401_0012, 32'h4004, 1'b0, 5'd0); step();
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL preflush_count got %0d want 2", count); end
    drive(1'b1, 32'h2401_0013, 32'h6000, 1'b1, 5'd0);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state got %0d/%0b want 0/0", count, out_valid); end
    n_checks++; if (PC_D !== 32'h5014) begin n_fail++; $display("FAIL flush_last_pc got %h want 5014", PC_D); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0 || PC_D !== 32'h5014) begin n_fail++; $display("FAIL flush_dropped got %0b/%h want 0/5014", out_valid, PC_D); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h2400_0000 | k, 32'h3000 + 4 * k, k[0], 5'd0);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || PC_D !== 32'h3000 + 4 * k || BD_D !== k[0] ||
          IR_D !== (32'h2400_0000 | k) || count !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%0b pc=%h bd=%0b ir=%h cnt=%0d want v=1 pc=%h bd=%0b ir=%h cnt=1",
                 k, out_valid, PC_D, BD_D, IR_D, count, 32'h3000 + 4 * k, k[0], 32'h2400_0000 | k);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    step();
    n_checks++; if (count !== 2'd0 || PC_D !== 32'h3024) begin n_fail++; $display("FAIL stream_end got %0d/%h want 0/3024", count, PC_D); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h2401_0021, 32'h7000, 1'b0, 5'd0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (count !== 2'd1 || PC_D !== 32'h7000) begin n_fail++; $display("FAIL prereset got %0d/%h want 1/7000", count, PC_D); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (PC_D !== 32'h3000) begin n_fail++; $display("FAIL async_PC_D got %h want 3000", PC_D); end
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_count got %0d/%0b want 0/0", count, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready got %0b want 1", in_ready); end
    #1;
    reset = 1'b0;
    drive(1'b1, 32'h4200_0018, 32'h8000, 1'b0, 5'd0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    n_checks++; if (out_valid !== 1'b1 || IR_D !== 32'h4200_0018) begin n_fail++; $display("FAIL eret_head got %0b/%h want 1/42000018", out_valid, IR_D); end
    n_checks++; if (excode_D !== 5'd0) begin n_fail++; $display("FAIL eret_exc got %0d want 0", excode_D); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_push_pop();
    test_ri();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_fetch_queue.md
Name: id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register. Sits between fetch and decode.
- Buffers up to DEPTH fetched instructions together with their PC, branch-delay flag and fetch-stage exception code, using valid/ready handshakes on both sides.
- Presents the head entry to decode as IR_D/PC_D/PC4_D/PC8_D/BD_D/excode_D.
- Merges fetch exceptions with the reserved-instruction (RI) check.
- Supports whole-queue flush on exception or eret.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- RI_CHECK, 1, 1 = decode-time RI detection enabled; 0 = excode_D carries the fetch exception only.
- EXC_RI, 10, excode reported for an unrecognised instruction.
- RESET_PC, 32'h00003000, reset value of the last-PC register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry this cycle.
- in_instr  in  32  fetched instruction word.
- in_pc  in  32  PC of the fetched instruction.
- in_bd  in  1  instruction sits in a branch delay slot.
- in_exc  in  5  fetch exception code (0 = none, e.g. 4 = AdEL).
- flush  in  1  synchronous discard of every entry.
- out_ready  in  1  decode accepts the head entry (deassert = stall).
- out_valid  out  1  head entry is present.
- IR_D  out  32  head instruction; 0 (nop) when empty.
- PC_D  out  32  head PC; when empty, PC of the last dequeued entry.
- PC4_D  out  32  PC_D+4, modulo 2^32.
- PC8_D  out  32  PC_D+8, modulo 2^32.
- BD_D  out  1  head delay-slot flag; 0 when empty.
- excode_D  out  5  head exception code; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer): count=0, read/write pointers=0, last_pc=RESET_PC.
  - Resulting outputs: out_valid=0, IR_D=0, PC_D=RESET_PC, PC4_D=RESET_PC+4, PC8_D=RESET_PC+8, BD_D=0, excode_D=0, in_ready=1.
- Storage: circular buffer of DEPTH entries {instr, pc, bd, exc}. Pointers are log2(DEPTH) bits and wrap naturally.
- push = in_valid & in_ready. Writes at wr_ptr; wr_ptr+1.
- pop = out_valid & out_ready. Advances rd_ptr; last_pc ← head pc.
- in_ready = (count<DEPTH) | out_ready. When full, a push is allowed in the same cycle as a pop; count stays DEPTH.
- out_valid = (count≠0).
- No bypass: an entry pushed into an empty queue appears on the outputs the next cycle (latency 1).
- Outputs are driven combinationally from the head register and last_pc only; there is no path from the in_* ports to the outputs.
- count next-state:
  - push & !pop → +1.
  - pop & !push → −1.
  - both or neither → unchanged.
- flush (synchronous): count←0 and rd_ptr←wr_ptr.
  - Overrides push and pop in the same cycle: the incoming entry is dropped and last_pc is not updated.
  - in_ready is unaffected by flush.
- excode_D priority (evaluated on the head entry):
  - out_valid=0 → 0.
  - else head exc≠0 → head exc.
  - else RI_CHECK=1 and instruction not recognised → EXC_RI.
  - else → 0.
- Recognised set (anything else raises RI):
  - opcodes j, jal, beq, bne, blez, bgtz, lui, ori, andi, xori, addi, addiu, slti, sltiu, lw, lb, lbu, lh, lhu, sw, sh, sb.
  - REGIMM with rt=0 or rt=1.
  - COP0 with rs=0 (mfc0) or rs=4 (mtc0).
  - Exact word 32'h42000018 (eret).
  - SPECIAL with funct in {jr, jalr, addu, subu, add, sub, sll, srl, sra, sllv, srlv, srav, and, or, nor, xor, slt, sltu, mult, multu, div, divu, mfhi, mflo, mthi, mtlo}.
  - All-zero word (sll nop) is therefore recognised.
- PC4_D/PC8_D are combinational adds on PC_D. Wrap at 2^32 without a flag.

Test Plan:
1. Reset, then push instr 32'h3C010001 (lui) pc 0x3000 → next cycle:
   - out_valid=1, IR_D=32'h3C010001, PC4_D=0x3004, PC8_D=0x3008, excode_D=0.
   - With out_ready=1, one cycle later: out_valid=0, IR_D=0, PC_D=0x3000.
2. out_ready=0, push DEPTH(=2) entries pc 0x3000/0x3004 → count=2, in_ready=0.
   - Raise out_ready with in_valid=1 pc 0x3008 → push and pop same cycle, count stays 2, head becomes 0x3004.
3. Push 32'hFC000000 (opcode 63) → excode_D=10.
   - Repeat with RI_CHECK=0 → excode_D=0.
   - Push it with in_exc=4 → excode_D=4 (fetch exception wins).
4. Queue holding 2 entries; assert flush together with in_valid and out_ready → next cycle:
   - count=0, out_valid=0, PC_D equals the value before the flush cycle (no pop recorded).
   - The pushed entry never appears.
5. Pointer wrap: stream 10 back-to-back entries pc 0x3000+4k with out_ready=1 and in_bd alternating → decode sees every pc in order, BD_D matching, no entry lost or duplicated.
6. Assert reset mid-stream asynchronously (between clock edges) with count=1 → outputs immediately show PC_D=32'h00003000, count=0, in_ready=1.
   - Fetch of word 32'h42000018 after release → excode_D=0.
